// File: rtl/sort_job_sequencer.sv
// sort_job_sequencer: loads a job into RAM, runs the sorter, streams results out; SORT_TIMEOUT_EN adds a SORT_WAIT watchdog
module sort_job_sequencer #(
  parameter int ADDR_W = 10,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              job_done,
  output logic              overflow,
  output logic [15:0]       count,
  output logic              srt_go,
  input  logic              srt_done,
  output logic [15:0]       srt_length,
  input  logic [31:0]       srt_addr,
  input  logic [31:0]       srt_wdata,
  output logic [31:0]       srt_rdata,
  input  logic              srt_we,
`ifdef SORT_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we
);
  typedef enum logic [2:0] {IDLE, LOAD, SORT_GO, SORT_WAIT, RD_ADDR, RD_DATA, RD_HOLD, DONE} state_t;
  localparam logic [15:0] DEPTH = 16'(1 << ADDR_W);
  state_t      state_q, state_d;
  logic [15:0] count_q, count_d, rptr_q, rptr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        overflow_q, overflow_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic        job_done_q, job_done_d, srt_go_q, srt_go_d, in_ready_q, in_ready_d;
  logic        accept, sorter_sel;
  logic        unused_addr_bits;
`ifdef SORT_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;
`endif
  assign accept = in_valid & in_ready_q;
  assign sorter_sel = state_q == SORT_WAIT;
  assign unused_addr_bits = ^srt_addr[31:ADDR_W];
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rptr_d = rptr_q;
    overflow_d = overflow_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
`ifdef SORT_TIMEOUT_EN
    wd_d = '0;
    tmo_d = tmo_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        count_d = 16'd1;
        overflow_d = 1'b0;
        rptr_d = '0;
`ifdef SORT_TIMEOUT_EN
        tmo_d = 1'b0;
`endif
        state_d = in_last ? RD_ADDR : LOAD;
      end
      LOAD: if (accept) begin
        count_d = count_q + 16'd1;
        overflow_d = !in_last && count_d == DEPTH;
        state_d = (in_last || overflow_d) ? SORT_GO : LOAD;
      end
      SORT_GO: state_d = SORT_WAIT;
      SORT_WAIT: begin
`ifdef SORT_TIMEOUT_EN
        wd_d = wd_q + 32'd1;
        tmo_d = !srt_done && wd_d == 32'(TIMEOUT_CYCLES);
        state_d = (srt_done || tmo_d) ? RD_ADDR : SORT_WAIT;
`else
        state_d = srt_done ? RD_ADDR : SORT_WAIT;
`endif
        rptr_d = '0;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        out_data_d = ram_rdata;
        out_valid_d = 1'b1;
        out_last_d = rptr_q == count_q - 16'd1;
        state_d = RD_HOLD;
      end
      RD_HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        rptr_d = rptr_q + 16'd1;
        state_d = out_last_q ? DONE : RD_ADDR;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE || state_d == LOAD;
    srt_go_d = state_d == SORT_GO;
    job_done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rptr_q <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      job_done_q <= 1'b0;
      srt_go_q <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef SORT_TIMEOUT_EN
      wd_q <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q <= rptr_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      job_done_q <= job_done_d;
      srt_go_q <= srt_go_d;
      in_ready_q <= in_ready_d;
`ifdef SORT_TIMEOUT_EN
      wd_q <= wd_d;
      tmo_q <= tmo_d;
`endif
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign busy = state_q != IDLE;
  assign job_done = job_done_q;
  assign overflow = overflow_q;
  assign count = count_q;
  assign srt_go = srt_go_q;
  assign srt_length = count_q - 16'(count_q != 16'd0);
  assign srt_rdata = ram_rdata;
`ifdef SORT_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif
  assign ram_addr = sorter_sel ? srt_addr[ADDR_W-1:0] : state_q == LOAD ? count_q[ADDR_W-1:0] : state_q == IDLE ? '0 : rptr_q[ADDR_W-1:0];
  assign ram_wdata = sorter_sel ? srt_wdata : in_data;
  assign ram_we = sorter_sel ? srt_we : accept;
endmodule

// File: doc/sort_job_sequencer.md
Name: sort_job_sequencer

Overview:
- Sequences one complete sort job around the in-place sorter engine and its single-port RAM.
- Streams words from a host into RAM, then pulses the sorter's go and waits for its done.
- Streams the sorted words back out to the host.
- Owns the RAM port mux: the host path drives RAM except while the sorter is running.

Parameters:
- ADDR_W, 10, RAM address width; capacity is DEPTH = 2**ADDR_W words.
- TIMEOUT_CYCLES, 1048576, watchdog limit in SORT_WAIT (used only with SORT_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  host write word valid
- in_ready  out  1  sequencer accepts in_data
- in_data  in  32  unsorted word
- in_last  in  1  marks final word of job
- out_valid  out  1  sorted word valid
- out_ready  in  1  host accepts out_data
- out_data  out  32  sorted word
- out_last  out  1  final sorted word
- busy  out  1  job in progress (state != IDLE)
- job_done  out  1  one-cycle pulse after last word is handed out
- overflow  out  1  sticky; job truncated at DEPTH words
- count  out  16  words in current job
- srt_go  out  1  go pulse to sorter
- srt_done  in  1  sorter done level
- srt_length  out  16  index of last element, count-1
- srt_addr  in  32  sorter address (low ADDR_W bits used)
- srt_wdata  in  32  sorter write data
- srt_rdata  out  32  RAM read data to sorter
- srt_we  in  1  sorter write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after address
- ram_we  out  1  RAM write enable

Behaviour:
- Reset (reset==0 at posedge): state=IDLE.
  - All outputs 0: in_ready, out_valid, out_data, out_last, busy, job_done, overflow, count, srt_go, ram_we, ram_addr, wptr.
- Reset mid-job aborts the job immediately. The sorter shares the same reset.
- States: IDLE, LOAD, SORT_GO, SORT_WAIT, RD_ADDR, RD_DATA, RD_HOLD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: clear count/overflow, write the word at address 0, count=1, go to LOAD (or straight on if in_last).
- LOAD:
  - in_ready=1. Each in_valid&in_ready writes in_data at ram_addr=count, ram_we=1 that cycle, count++.
  - On an accepted in_last: go to SORT_GO if count_after>=2, else RD_ADDR. A single word bypasses the sorter.
  - When count reaches DEPTH without in_last: set overflow, in_ready=0, go to SORT_GO. Remaining host words are not accepted until IDLE.
- SORT_GO:
  - srt_length=count-1, held stable through SORT_WAIT.
  - srt_go=1 for exactly one cycle, then SORT_WAIT.
- SORT_WAIT:
  - RAM mux selects the sorter: ram_addr=srt_addr[ADDR_W-1:0], ram_wdata=srt_wdata, ram_we=srt_we.
  - srt_done is sampled only in this state, starting the cycle after srt_go. The sorter clears done on the go edge.
  - srt_done==1 -> RD_ADDR, rptr=0.
- srt_rdata=ram_rdata at all times.
- In all other states the sequencer drives RAM; ram_we=0 except on accepted LOAD/IDLE writes.
- Readout, 3 cycles per word minimum:
  - RD_ADDR: ram_addr=rptr.
  - RD_DATA: out_data<=ram_rdata, out_valid<=1, out_last<=(rptr==count-1).
  - RD_HOLD: hold out_data/out_valid stable until out_ready.
  - On the handshake: out_valid=0, rptr++. Then RD_ADDR if not last, else DONE.
- DONE: job_done=1 for one cycle, then IDLE. count and overflow are held until the next job starts.
- out_valid never drops without a handshake. in_ready=0 in all states except IDLE and LOAD.

Optional Feature:
- SORT_TIMEOUT_EN defined:
  - 32-bit watchdog counts cycles in SORT_WAIT.
  - On reaching TIMEOUT_CYCLES: sticky timeout_err output goes to 1, state moves to RD_ADDR, and RAM contents are streamed as-is.
  - timeout_err is cleared on IDLE->LOAD.
- Undefined: no counter and no timeout_err port; SORT_WAIT waits indefinitely.

Test Plan:
- Load 5,3,9,1 (last on 1) -> srt_go single pulse, srt_length=3; output 1,3,5,9 with out_last on 9; job_done pulse; count=4.
- Single word 0x42 with in_last -> srt_go never asserted; output 0x42 with out_last; job_done.
- ADDR_W=3, stream 10 words with no in_last -> 8 accepted, in_ready=0 afterwards, overflow=1, srt_length=7, 8 sorted words out.
- Readout with out_ready held low 20 cycles on word 2 -> out_data/out_valid stable; no skipped or duplicated word; order preserved.
- Assert reset=0 during SORT_WAIT -> next edge busy=0, srt_go=0, ram_we=0, out_valid=0, state IDLE; a new job then runs correctly.
- SORT_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a stub sorter whose done never rises -> timeout_err=1 after 16 SORT_WAIT cycles; unsorted words streamed; job_done.
